// File: rtl/double_divider_pkg.sv
// Shared types and constants for the double-precision divider arbiter.
package double_divider_pkg;

    localparam int unsigned DBL_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitZ,
        StRsp
    } arb_state_e;

    // IEEE-754 double bit patterns for common small values.
    localparam logic [DBL_WIDTH-1:0] DblQuarter = 64'h3FD0_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblHalf    = 64'h3FE0_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblOne     = 64'h3FF0_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblTwo     = 64'h4000_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblThree   = 64'h4008_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblFour    = 64'h4010_0000_0000_0000;
    localparam logic [DBL_WIDTH-1:0] DblSix     = 64'h4018_0000_0000_0000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    assign any_o = |req_i;

    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (32'(ptr_i) + k) % N_REQ;
            if ((gnt_o == '0) && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/double_divider_arbiter.sv
// Round-robin arbiter sharing one double_divider_newton between N_REQ requesters;
// owns all divider handshakes and returns each quotient to its requester only.
module double_divider_arbiter
    import double_divider_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = DBL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_z,
    input  logic [N_REQ-1:0]         rsp_ack,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    output logic                     div_a_stb,
    output logic                     div_b_stb,
    input  logic                     div_a_ack,
    input  logic                     div_b_ack,
    input  logic [WIDTH-1:0]         div_z,
    input  logic                     div_z_stb,
    output logic                     div_z_ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             a_stb_q, a_stb_d;
    logic             b_stb_q, b_stb_d;
    logic             z_ack_q, z_ack_d;
    logic [N_REQ-1:0] ready_q, ready_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        a_stb_d = a_stb_q;
        b_stb_d = b_stb_q;
        z_ack_d = 1'b0;
        ready_d = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    a_d     = req_a[pick_idx*WIDTH +: WIDTH];
                    b_d     = req_b[pick_idx*WIDTH +: WIDTH];
                    ready_d = pick_gnt;
                    a_stb_d = 1'b1;
                    b_stb_d = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                // A strobe already low means its operand is done; acks then are no-ops.
                if (div_a_ack) a_stb_d = 1'b0;
                if (div_b_ack) b_stb_d = 1'b0;
                if (!a_stb_d && !b_stb_d) state_d = StWaitZ;
            end
            StWaitZ: begin
                if (div_z_stb) begin
                    z_d     = div_z;
                    z_ack_d = 1'b1;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ack[grant_q]) begin
                    ptr_d   = (grant_q == IdxW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            a_stb_q <= a_stb_d;
            b_stb_q <= b_stb_d;
            z_ack_q <= z_ack_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == StRsp) rsp_valid[grant_q] = 1'b1;
    end

    assign req_ready = ready_q;
    assign rsp_z     = z_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign div_a_stb = a_stb_q;
    assign div_b_stb = b_stb_q;
    assign div_z_ack = z_ack_q;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_double_divider_arbiter.sv
// Scoreboard bench: directed requests, a behavioural divider model and a response monitor.
`timescale 1ns/1ps
module tb_double_divider_arbiter;
    import double_divider_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = DBL_WIDTH;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [W-1:0]    rsp_z;
    logic [NR-1:0]   rsp_ack;
    logic [W-1:0]    div_a;
    logic [W-1:0]    div_b;
    logic            div_a_stb;
    logic            div_b_stb;
    logic            div_a_ack;
    logic            div_b_ack;
    logic [W-1:0]    div_z;
    logic            div_z_stb;
    logic            div_z_ack;
    logic            busy;
    logic [1:0]      grant_id;

    double_divider_arbiter #(
        .N_REQ (NR),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .rsp_ack   (rsp_ack),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_a_stb (div_a_stb),
        .div_b_stb (div_b_stb),
        .div_a_ack (div_a_ack),
        .div_b_ack (div_b_ack),
        .div_z     (div_z),
        .div_z_stb (div_z_stb),
        .div_z_ack (div_z_ack),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        int           id;
        logic [W-1:0] z;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   rsp_cnt = 0;
    int   ready_cnt[NR];
    bit   persist[NR];
    int   a_delay = 1;
    int   b_delay = 1;
    int   z_delay = 2;
    int   ack_delay = 2;
    bit   stray_z = 1'b0;
    int   m_st = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic submit(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] z);
        exp_t e;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        e.id = id;
        e.z  = z;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input int target);
        int guard;
        guard = 0;
        while (rsp_cnt < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_cnt < target) timeout_fail("wait_rsp");
    endtask

    task automatic wait_done(input int target);
        wait_rsp(target);
        repeat (ack_delay + 3) @(negedge clk);
        chk("idle_after_ack", busy, 0);
    endtask

    // Requester side: drop valid once ready is seen unless held persistently.
    initial begin : requesters
        forever begin
            @(negedge clk);
            if (req_ready != '0) chk("ready_onehot", $onehot(req_ready), 1);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    ready_cnt[i]++;
                    chk("stb_with_ready", {div_a_stb, div_b_stb}, 2'b11);
                    chk("grant_id_at_ready", grant_id, i);
                    chk("ready_was_valid", req_valid[i], 1);
                    if (!persist[i]) req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Behavioural divider: configurable ack delays, optional stray result strobe.
    initial begin : div_model
        logic [W-1:0] m_a;
        logic [W-1:0] m_b;
        bit           a_done;
        bit           b_done;
        int           cnt;
        div_a_ack = 1'b0;
        div_b_ack = 1'b0;
        div_z_stb = 1'b0;
        div_z     = '0;
        m_a = '0;
        m_b = '0;
        a_done = 1'b0;
        b_done = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            div_a_ack = 1'b0;
            div_b_ack = 1'b0;
            if (!rst) begin
                m_st = 0;
                div_z_stb = 1'b0;
                continue;
            end
            cnt++;
            case (m_st)
                0: begin
                    if (div_a_stb || div_b_stb) begin
                        m_a = div_a;
                        m_b = div_b;
                        a_done = 1'b0;
                        b_done = 1'b0;
                        cnt = 0;
                        m_st = 1;
                    end
                end
                1: begin
                    chk("no_zack_in_send", div_z_ack, 0);
                    chk("a_stb_level", div_a_stb, !a_done);
                    chk("b_stb_level", div_b_stb, !b_done);
                    if (!a_done) chk("div_a_stable", div_a, m_a);
                    if (!b_done) chk("div_b_stable", div_b, m_b);
                    if (stray_z) begin
                        if (cnt == 1) div_z_stb = 1'b1;
                        else if (cnt == 2) begin
                            div_z_stb = 1'b0;
                            stray_z = 1'b0;
                        end
                    end
                    if (!a_done && cnt == a_delay) begin
                        div_a_ack = 1'b1;
                        a_done = 1'b1;
                    end
                    if (!b_done && cnt == b_delay) begin
                        div_b_ack = 1'b1;
                        b_done = 1'b1;
                    end
                    if (a_done && b_done) begin
                        m_st = 2;
                        cnt = 0;
                    end
                end
                2: begin
                    if (cnt == 1) chk("stbs_cleared", {div_a_stb, div_b_stb}, 0);
                    if (cnt >= z_delay) begin
                        div_z = $realtobits($bitstoreal(m_a) / $bitstoreal(m_b));
                        div_z_stb = 1'b1;
                        m_st = 3;
                        cnt = 0;
                    end
                end
                3: begin
                    if (div_z_ack) begin
                        div_z_stb = 1'b0;
                        m_st = 4;
                    end else if (cnt > 200) begin
                        timeout_fail("div_z_ack");
                        div_z_stb = 1'b0;
                        m_st = 0;
                    end
                end
                default: begin
                    chk("zack_one_cycle", div_z_ack, 0);
                    m_st = 0;
                end
            endcase
        end
    end

    // Response monitor: pops the scoreboard on each new response, then acks it.
    initial begin : monitor
        bit           seen;
        int           wcnt;
        logic [NR-1:0] held_v;
        logic [W-1:0] held_z;
        exp_t         e;
        seen = 1'b0;
        wcnt = 0;
        held_v = '0;
        held_z = '0;
        rsp_ack = '0;
        forever begin
            @(negedge clk);
            rsp_ack = '0;
            if (!rst) begin
                seen = 1'b0;
                continue;
            end
            if (rsp_valid != '0) begin
                if (!seen) begin
                    seen = 1'b1;
                    wcnt = 0;
                    held_v = rsp_valid;
                    held_z = rsp_z;
                    chk("rsp_onehot", $onehot(rsp_valid), 1);
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_rsp");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_valid, 64'd1 << e.id);
                        chk("rsp_grant_id", grant_id, e.id);
                        chk("rsp_z", rsp_z, e.z);
                    end
                    rsp_cnt++;
                end else begin
                    wcnt++;
                    chk("rsp_valid_stable", rsp_valid, held_v);
                    chk("rsp_z_stable", rsp_z, held_z);
                    chk("no_grant_in_rsp", req_ready, 0);
                end
                if (ack_delay >= 5 && wcnt == 1) rsp_ack = ~rsp_valid;
                if (wcnt == ack_delay) rsp_ack = rsp_valid;
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            ready_cnt[i] = 0;
            persist[i] = 1'b0;
        end
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_stbs", {div_a_stb, div_b_stb, div_z_ack}, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_div_a", div_a, 0);
        rst = 1'b1;

        // Contention: all four at once, served 0..3.
        @(negedge clk);
        for (int i = 0; i < NR; i++) submit(i, DblOne, DblFour, DblQuarter);
        wait_done(4);

        // Fairness: 1 and 3 held valid alternate.
        persist[1] = 1'b1;
        persist[3] = 1'b1;
        submit(1, DblSix, DblTwo, DblThree);
        submit(3, DblOne, DblFour, DblQuarter);
        submit(1, DblSix, DblTwo, DblThree);
        submit(3, DblOne, DblFour, DblQuarter);
        wait_rsp(8);
        persist[1] = 1'b0;
        persist[3] = 1'b0;
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b0;
        wait_done(8);

        // Single request 6.0 / 2.0.
        ready_cnt[0] = 0;
        submit(0, DblSix, DblTwo, DblThree);
        wait_done(9);
        chk("single_ready_pulses", ready_cnt[0], 1);

        // Staggered acks: b five cycles ahead of a.
        a_delay = 6;
        b_delay = 1;
        submit(0, DblOne, DblTwo, DblHalf);
        wait_done(10);
        a_delay = 1;
        b_delay = 1;

        // Stray result strobe in SEND, slow rsp_ack, second requester waiting.
        a_delay = 3;
        b_delay = 3;
        stray_z = 1'b1;
        ack_delay = 50;
        submit(3, DblSix, DblTwo, DblThree);
        repeat (2) @(negedge clk);
        submit(1, DblOne, DblFour, DblQuarter);
        wait_done(12);
        a_delay = 1;
        b_delay = 1;
        ack_delay = 2;

        // Reset while waiting for the divider result.
        z_delay = 20;
        submit(1, DblSix, DblTwo, DblThree);
        guard = 0;
        while (m_st != 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (m_st != 2) timeout_fail("reach_wait_z");
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_stbs", {div_a_stb, div_b_stb, div_z_ack}, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_div_a", div_a, 0);
        chk("arst_div_b", div_b, 0);
        chk("arst_ptr", dut.ptr_q, 0);
        if (sb.size() > 0) void'(sb.pop_back());
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        z_delay = 2;
        @(negedge clk);
        submit(2, DblOne, DblTwo, DblHalf);
        wait_done(13);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/double_divider_arbiter.md
# double_divider_arbiter

Shares one `double_divider_newton` instance between `N_REQ` requesters. Each requester submits an operand pair (a, b). The block grants requesters round-robin and drives the divider's stb/ack input handshakes. It then collects `output_z` and returns the quotient to the granted requester only. It sits between the requesting datapath blocks and the single divider and owns all divider handshake signals.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 64: operand/result width (IEEE-754 double).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i has an operand pair pending; held until its `req_ready` bit is seen.
- `req_a` in N_REQ*WIDTH: dividends; slice i = `[i*WIDTH +: WIDTH]`.
- `req_b` in N_REQ*WIDTH: divisors; same slicing.
- `req_ready` out N_REQ: one-cycle pulse; operands of requester i captured.
- `rsp_valid` out N_REQ: quotient for requester i on `rsp_z`; held until acked.
- `rsp_z` out WIDTH: latched quotient, shared by all requesters.
- `rsp_ack` in N_REQ: requester i consumed `rsp_z`.
- `div_a`, `div_b` out WIDTH: operands to the divider.
- `div_a_stb`, `div_b_stb` out 1: operand strobes.
- `div_a_ack`, `div_b_ack` in 1: divider operand acks.
- `div_z` in WIDTH: divider result.
- `div_z_stb` in 1: result strobe.
- `div_z_ack` out 1: result ack.
- `busy` out 1: state ≠ IDLE.
- `grant_id` out clog2(N_REQ): index of the current or last grant.

## Operation
- Reset values: state IDLE, round-robin pointer 0, `grant_id` 0, operand registers 0, `rsp_z` 0. All strobes, acks, `req_ready`, `rsp_valid` and `busy` are 0.
- FSM states: IDLE → SEND → WAIT_Z → RSP → IDLE.
- **IDLE**
  - When any `req_valid` bit is high at an edge, pick the first set bit searching from pointer, wrapping modulo N_REQ.
  - At that edge: latch `req_a`/`req_b` of the winner, set `grant_id`, pulse `req_ready[g]` for one cycle, set `div_a_stb` and `div_b_stb`, and go to SEND.
- **SEND**
  - Each strobe clears at the edge where it and its ack are both high.
  - The a and b handshakes complete independently; a done-flag is tracked per operand.
  - When both are done, go to WAIT_Z.
  - `div_a`/`div_b` stay stable from grant until both acks complete.
- **WAIT_Z**
  - On an edge with `div_z_stb`=1: latch `div_z` into `rsp_z`, drive `div_z_ack`=1 for exactly one cycle, and go to RSP.
- **RSP**
  - `rsp_valid[g]`=1; all other bits stay 0.
  - On an edge with `rsp_ack[g]`=1: clear `rsp_valid`, set pointer = (g+1) mod N_REQ, and go to IDLE.
- Only one transaction is in flight at a time. No new grant is issued while `busy`=1.
- Stray inputs:
  - `div_z_stb` outside WAIT_Z is ignored and never acked.
  - `rsp_ack` bits other than g are ignored.
  - `div_*_ack` outside SEND is ignored.
- No arithmetic is performed on operands; they pass through bit-exactly.

## Timing
- Grant to strobes: `div_*_stb` rises in the same cycle as `req_ready` (both registered from the grant edge).
- Overhead around divider latency:
  - The block adds 1 cycle in IDLE before strobes rise.
  - The result is visible on `rsp_z` 1 cycle after the `div_z_stb` capture edge.
  - The return to IDLE takes 1 cycle after `rsp_ack`.
  - A back-to-back grant is possible on the first IDLE edge.
- Simultaneous requests: the lowest index at or after the pointer wins. The other requesters keep `req_valid` high and are served in later rounds; no starvation.
- Simultaneous acks: `div_a_ack` and `div_b_ack` arriving on the same edge complete SEND in one cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously), and the pending transaction is dropped. The divider shares `rst` and is reset together with the arbiter.
- The RSP state does not time out; the block waits indefinitely for `rsp_ack`.

## Structure
- The shared package `double_divider_pkg` holds:
  - the FSM state encoding (IDLE, SEND, WAIT_Z, RSP);
  - the `DBL_WIDTH`=64 constant;
  - the double test constants used by the bench.
- Sub-module `rr_picker`: combinational. Inputs are the request vector and the pointer; outputs are the one-hot grant and its index. Parameterised by N_REQ.
- The FSM, operand/result registers and handshake flags live in `double_divider_arbiter`.

## Test plan
- Single request: requester 0 submits 0x4018000000000000 / 0x4000000000000000 (6.0/2.0). Expect one `req_ready[0]` pulse, each strobe cleared once after its ack, `rsp_valid[0]` with `rsp_z`=0x4008000000000000 (3.0), and `busy` returning to 0 after `rsp_ack[0]`.
- Contention: all 4 requesters valid at once with 1.0/4.0 (0x3FF0…/0x4010…). Expect grants in order 0, 1, 2, 3, each returning 0x3FD0000000000000, and never two `rsp_valid` bits high together.
- Fairness: requesters 1 and 3 kept permanently valid. Expect grants to alternate 1, 3, 1, 3; `grant_id` matches each `rsp_valid` bit.
- Staggered acks: the bench model acks b 5 cycles before a. Expect `div_b_stb` to drop first, `div_a_stb` to stay high until its ack, and no transition to WAIT_Z before both complete.
- Stray and slow response: pulse `div_z_stb` during SEND, then delay `rsp_ack` by 50 cycles. Expect no `div_z_ack` in SEND, `rsp_valid` held stable, and no new grant until the ack.
- Reset mid-WAIT_Z: assert `rst`=0 asynchronously. Expect all outputs at reset values within the same cycle and pointer at 0. After release, a new request from requester 2 is granted normally.
